nesctrl_reader: RTL and testbench

Serial reader for two NES game controllers, built around the 4021 shift-register protocol. It runs a periodic poll and drives a shared latch and clock sequence to each controller port. It samples both serial data lines in parallel and presents two 8-bit active-high button words with a one-cycle valid strobe. It sits inside `system`, between the board-level `nesctrl_*` pins and the CPU-visible peripheral registers / `nesctrl_ctrl2_data` LED output.

---
 rtl/nesctrl_pkg.sv | 28 ++
 rtl/nesctrl_sync.sv | 31 +++
 rtl/nesctrl_reader.sv | 163 ++++++++++++++++
 tb/tb_nesctrl_reader.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nesctrl_pkg.sv
// nesctrl_pkg: shared definitions for the NES controller reader.
//   - state_e      : reader FSM states
//   - BTN_*        : bit positions of each button in the 8-bit button words
//   - *_CYC_DEF    : default timing for a 100 MHz system clock
package nesctrl_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StLatch,
      StLow,
      StHigh,
      StDone
   } state_e;

   localparam int unsigned BTN_A      = 7;
   localparam int unsigned BTN_B      = 6;
   localparam int unsigned BTN_SELECT = 5;
   localparam int unsigned BTN_START  = 4;
   localparam int unsigned BTN_UP     = 3;
   localparam int unsigned BTN_DOWN   = 2;
   localparam int unsigned BTN_LEFT   = 1;
   localparam int unsigned BTN_RIGHT  = 0;

   localparam int unsigned LATCH_CYC_DEF = 1200;    // 12 us
   localparam int unsigned HALF_CYC_DEF  = 600;     // 6 us
   localparam int unsigned POLL_CYC_DEF  = 1666667; // 60 Hz

endpackage

// File: rtl/nesctrl_sync.sv
// nesctrl_sync: two-flop synchronizer for one asynchronous input.
// Ports:
//   clk_i   system clock
//   rst_ni  synchronous active-low reset
//   d_i     asynchronous input
//   q_o     synchronized output (two clk_i cycles of latency)
module nesctrl_sync #(
   parameter logic ResetVal = 1'b1
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         meta_q <= ResetVal;
         sync_q <= ResetVal;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/nesctrl_reader.sv
// nesctrl_reader: periodic serial reader for two NES (4021-based) controllers.
// A free-running poll counter starts a frame: latch pulse, then eight LOW/HIGH
// half-periods of the shift clock, sampling both data lines at the end of each
// LOW half. The finished words are published with a one-cycle valid strobe.
// Ports:
//   clk                 system clock
//   rst                 synchronous active-low reset
//   nesctrl_ctrl1_q7    controller 1 serial data (async, buttons active-low)
//   nesctrl_ctrl2_q7    controller 2 serial data (async, buttons active-low)
//   nesctrl_pl1/_pl2    parallel-load (latch) to each controller
//   nesctrl_clk1/_clk2  shift clock to each controller
//   ctrl1_data          controller 1 buttons, active-high, A at [7]
//   nesctrl_ctrl2_data  controller 2 buttons, active-high, A at [7]
//   data_valid          one-cycle strobe, new words visible this cycle
module nesctrl_reader
   import nesctrl_pkg::*;
#(
   parameter int unsigned LATCH_CYC = LATCH_CYC_DEF,
   parameter int unsigned HALF_CYC  = HALF_CYC_DEF,
   parameter int unsigned POLL_CYC  = POLL_CYC_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       nesctrl_ctrl1_q7,
   input  logic       nesctrl_ctrl2_q7,
   output logic       nesctrl_pl1,
   output logic       nesctrl_pl2,
   output logic       nesctrl_clk1,
   output logic       nesctrl_clk2,
   output logic [7:0] ctrl1_data,
   output logic [7:0] nesctrl_ctrl2_data,
   output logic       data_valid
);

   localparam int unsigned PhMax = (LATCH_CYC > HALF_CYC) ? LATCH_CYC : HALF_CYC;
   localparam int unsigned PhW   = $clog2(PhMax);
   localparam int unsigned PollW = $clog2(POLL_CYC);

   localparam logic [PhW-1:0]   LatchLast = PhW'(LATCH_CYC - 1);
   localparam logic [PhW-1:0]   HalfLast  = PhW'(HALF_CYC - 1);
   localparam logic [PollW-1:0] PollLast  = PollW'(POLL_CYC - 1);

   logic             q7_1_sync;
   logic             q7_2_sync;

   logic [PollW-1:0] poll_q, poll_d;
   logic             tick;

   state_e           state_q;
   logic [PhW-1:0]   ph_q;
   logic [2:0]       bit_cnt_q;
   logic [7:0]       sr1_q, sr2_q;
   logic [7:0]       data1_q, data2_q;
   logic             pl_q;
   logic             sclk_q;
   logic             valid_q;

   // Idle line level is high (no button pressed), so reset to 1.
   nesctrl_sync #(.ResetVal(1'b1)) u_sync1 (
      .clk_i  (clk),
      .rst_ni (rst),
      .d_i    (nesctrl_ctrl1_q7),
      .q_o    (q7_1_sync)
   );

   nesctrl_sync #(.ResetVal(1'b1)) u_sync2 (
      .clk_i  (clk),
      .rst_ni (rst),
      .d_i    (nesctrl_ctrl2_q7),
      .q_o    (q7_2_sync)
   );

   // Free-running poll counter; the tick is the wrap cycle.
   always_comb begin
      tick   = (poll_q == PollLast);
      poll_d = tick ? '0 : poll_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         poll_q    <= '0;
         state_q   <= StIdle;
         ph_q      <= '0;
         bit_cnt_q <= '0;
         sr1_q     <= '0;
         sr2_q     <= '0;
         data1_q   <= '0;
         data2_q   <= '0;
         pl_q      <= 1'b0;
         sclk_q    <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         poll_q  <= poll_d;
         valid_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               // Ticks outside IDLE are dropped, so a frame never restarts.
               if (tick) begin
                  state_q <= StLatch;
                  pl_q    <= 1'b1;
                  ph_q    <= '0;
               end
            end
            StLatch: begin
               if (ph_q == LatchLast) begin
                  state_q   <= StLow;
                  pl_q      <= 1'b0;
                  ph_q      <= '0;
                  bit_cnt_q <= '0;
               end else begin
                  ph_q <= ph_q + 1'b1;
               end
            end
            StLow: begin
               if (ph_q == HalfLast) begin
                  // Data line has been stable for a full half-period here.
                  sr1_q <= {sr1_q[6:0], ~q7_1_sync};
                  sr2_q <= {sr2_q[6:0], ~q7_2_sync};
                  ph_q  <= '0;
                  if (bit_cnt_q == 3'd7) begin
                     state_q <= StDone;
                  end else begin
                     state_q <= StHigh;
                     sclk_q  <= 1'b1;
                  end
               end else begin
                  ph_q <= ph_q + 1'b1;
               end
            end
            StHigh: begin
               if (ph_q == HalfLast) begin
                  state_q   <= StLow;
                  sclk_q    <= 1'b0;
                  ph_q      <= '0;
                  bit_cnt_q <= bit_cnt_q + 1'b1;
               end else begin
                  ph_q <= ph_q + 1'b1;
               end
            end
            StDone: begin
               data1_q <= sr1_q;
               data2_q <= sr2_q;
               valid_q <= 1'b1;
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
               pl_q    <= 1'b0;
               sclk_q  <= 1'b0;
            end
         endcase
      end
   end

   assign nesctrl_pl1        = pl_q;
   assign nesctrl_pl2        = pl_q;
   assign nesctrl_clk1       = sclk_q;
   assign nesctrl_clk2       = sclk_q;
   assign ctrl1_data         = data1_q;
   assign nesctrl_ctrl2_data = data2_q;
   assign data_valid         = valid_q;

endmodule

// File: tb/tb_nesctrl_reader.sv
// tb_nesctrl_reader: bench for nesctrl_reader with a behavioural 4021 per port.
// Expected button words are queued when buttons are set and popped on data_valid.
module tb_nesctrl_reader;

   localparam int unsigned LatchCyc = 4;
   localparam int unsigned HalfCyc  = 4;
   localparam int unsigned PollCyc  = 100;

   logic       clk = 1'b0;
   logic       rst;
   logic       q7_1, q7_2;
   logic       pl1, pl2, sclk1, sclk2;
   logic [7:0] data1, data2;
   logic       dv;

   logic [7:0] btn1 = 8'h00;
   logic [7:0] btn2 = 8'h00;
   logic       disc2 = 1'b0;
   logic       ovr1_en = 1'b0;
   logic       ovr1_val = 1'b1;
   logic [7:0] sh1 = 8'hFF;
   logic [7:0] sh2 = 8'hFF;

   int         n_tests = 0;
   int         n_fail = 0;
   int         cyc = 0;
   logic [15:0] exp_q[$];

   nesctrl_reader #(
      .LATCH_CYC (LatchCyc),
      .HALF_CYC  (HalfCyc),
      .POLL_CYC  (PollCyc)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .nesctrl_ctrl1_q7   (q7_1),
      .nesctrl_ctrl2_q7   (q7_2),
      .nesctrl_pl1        (pl1),
      .nesctrl_pl2        (pl2),
      .nesctrl_clk1       (sclk1),
      .nesctrl_clk2       (sclk2),
      .ctrl1_data         (data1),
      .nesctrl_ctrl2_data (data2),
      .data_valid         (dv)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // 4021 model: parallel load while pl is high, shift toward Q7 on clk rise.
   always @(posedge sclk1 or posedge pl1) begin
      if (pl1) sh1 <= ~btn1;
      else     sh1 <= {sh1[6:0], 1'b1};
   end
   always @(posedge sclk2 or posedge pl2) begin
      if (pl2) sh2 <= ~btn2;
      else     sh2 <= {sh2[6:0], 1'b1};
   end

   assign q7_1 = ovr1_en ? ovr1_val : sh1[7];
   assign q7_2 = disc2 ? 1'b1 : sh2[7];

   task automatic wait_pl(output int n, output int k, output bit ok);
      ok = 1'b0; n = 0; k = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (pl1) begin
            ok = 1'b1; n = i + 1; k = cyc;
            break;
         end
      end
   endtask

   task automatic wait_dv(output int k, output bit ok);
      ok = 1'b0; k = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (dv) begin
            ok = 1'b1; k = cyc;
            break;
         end
      end
   endtask

   task automatic test_reset;
      int n, k;
      bit ok;
      logic [15:0] e;
      rst = 1'b0;
      repeat (10) @(negedge clk);
      n_tests++;
      if ({pl1, pl2, sclk1, sclk2, dv} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_lines: got %b want 00000", {pl1, pl2, sclk1, sclk2, dv});
      end
      n_tests++;
      if ({data1, data2} !== 16'h0000) begin
         n_fail++;
         $display("FAIL reset_words: got %h want 0000", {data1, data2});
      end
      exp_q.push_back(16'h0000);
      rst = 1'b1;
      wait_pl(n, k, ok);
      n_tests++;
      if (!ok || n != PollCyc) begin
         n_fail++;
         $display("FAIL reset_first_tick: pl after %0d cycles (seen=%0b) want %0d", n, ok, PollCyc);
      end
      wait_dv(k, ok);
      n_tests++;
      if (!ok || exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL reset_frame: data_valid seen=%0b queue=%0d", ok, exp_q.size());
      end else begin
         e = exp_q.pop_front();
         if ({data1, data2} !== e) begin
            n_fail++;
            $display("FAIL reset_frame: got %h want %h", {data1, data2}, e);
         end
      end
   endtask

   task automatic test_pattern;
      int k;
      bit ok;
      logic [15:0] e;
      btn1 = 8'h5A; btn2 = 8'hC3;
      exp_q.push_back({8'h5A, 8'hC3});
      wait_dv(k, ok);
      n_tests++;
      if (!ok || exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL pattern_words: data_valid seen=%0b queue=%0d", ok, exp_q.size());
      end else begin
         e = exp_q.pop_front();
         if ({data1, data2} !== e) begin
            n_fail++;
            $display("FAIL pattern_words: got %h want %h", {data1, data2}, e);
         end
      end
      @(negedge clk);
      n_tests++;
      if (dv !== 1'b0) begin
         n_fail++;
         $display("FAIL pattern_dv_width: data_valid=%b on second cycle want 0", dv);
      end
   endtask

   task automatic test_waveform;
      int n, k, dv_cyc, pl_hi, pulses, bad, mism, hi, lo;
      bit ok, got;
      logic prev;
      logic [15:0] e;
      btn1 = 8'h81; btn2 = 8'h18;
      exp_q.push_back({8'h81, 8'h18});
      wait_pl(n, k, ok);
      pl_hi = 1; pulses = 0; bad = 0; hi = 0; lo = 0; got = 1'b0; dv_cyc = 0;
      mism = (pl1 !== pl2 || sclk1 !== sclk2) ? 1 : 0;
      prev = sclk1;
      for (int i = 0; i < 200 && ok; i++) begin
         @(negedge clk);
         if (pl1 !== pl2 || sclk1 !== sclk2) mism++;
         if (pl1) pl_hi++;
         if (dv) begin
            got = 1'b1; dv_cyc = cyc;
            break;
         end
         if (sclk1 && !prev) begin
            pulses++;
            if (pulses > 1 && lo != HalfCyc) bad++;
            hi = 1;
         end else if (!sclk1 && prev) begin
            if (hi != HalfCyc) bad++;
            lo = 1;
         end else if (sclk1) begin
            hi++;
         end else begin
            lo++;
         end
         prev = sclk1;
      end
      n_tests++;
      if (pl_hi != LatchCyc) begin
         n_fail++;
         $display("FAIL wave_pl_width: got %0d want %0d", pl_hi, LatchCyc);
      end
      n_tests++;
      if (pulses != 7) begin
         n_fail++;
         $display("FAIL wave_pulses: got %0d want 7", pulses);
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL wave_half_periods: %0d bad runs want 0", bad);
      end
      n_tests++;
      if (mism != 0) begin
         n_fail++;
         $display("FAIL wave_pair_equal: %0d unequal cycles want 0", mism);
      end
      n_tests++;
      // Tick is the cycle before pl first reads high.
      if (!got || dv_cyc - (k - 1) != 66) begin
         n_fail++;
         $display("FAIL wave_dv_latency: got %0d (seen=%0b) want 66", dv_cyc - (k - 1), got);
      end
      n_tests++;
      if (!got || exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL wave_words: data_valid seen=%0b queue=%0d", got, exp_q.size());
      end else begin
         e = exp_q.pop_front();
         if ({data1, data2} !== e) begin
            n_fail++;
            $display("FAIL wave_words: got %h want %h", {data1, data2}, e);
         end
      end
   endtask

   task automatic test_extremes;
      int k;
      bit ok;
      logic [15:0] e;
      btn1 = 8'hFF; btn2 = 8'h5A; disc2 = 1'b1;
      exp_q.push_back({8'hFF, 8'h00});
      wait_dv(k, ok);
      n_tests++;
      if (!ok || exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL extremes_words: data_valid seen=%0b queue=%0d", ok, exp_q.size());
      end else begin
         e = exp_q.pop_front();
         if ({data1, data2} !== e) begin
            n_fail++;
            $display("FAIL extremes_words: got %h want %h", {data1, data2}, e);
         end
      end
      disc2 = 1'b0;
   endtask

   task automatic test_hold;
      int k, d1, viol;
      bit ok;
      logic [15:0] e;
      btn1 = 8'h12; btn2 = 8'h34;
      exp_q.push_back({8'h12, 8'h34});
      wait_dv(d1, ok);
      n_tests++;
      if (!ok || exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL hold_first: data_valid seen=%0b queue=%0d", ok, exp_q.size());
      end else begin
         e = exp_q.pop_front();
         if ({data1, data2} !== e) begin
            n_fail++;
            $display("FAIL hold_first: got %h want %h", {data1, data2}, e);
         end
      end
      btn1 = 8'hAB; btn2 = 8'hCD;
      exp_q.push_back({8'hAB, 8'hCD});
      viol = 0;
      for (int i = 1; i < PollCyc; i++) begin
         @(negedge clk);
         if (dv !== 1'b0 || {data1, data2} !== 16'h1234) viol++;
      end
      n_tests++;
      if (viol != 0) begin
         n_fail++;
         $display("FAIL hold_stable: %0d cycles changed want 0", viol);
      end
      @(negedge clk);
      n_tests++;
      if (dv !== 1'b1 || cyc - d1 != PollCyc) begin
         n_fail++;
         $display("FAIL hold_spacing: dv=%b after %0d cycles want 1 after %0d", dv, cyc - d1, PollCyc);
         wait_dv(k, ok);
      end
      n_tests++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL hold_update: queue empty want 1 entry");
      end else begin
         e = exp_q.pop_front();
         if ({data1, data2} !== e) begin
            n_fail++;
            $display("FAIL hold_update: got %h want %h", {data1, data2}, e);
         end
      end
   endtask

   task automatic test_late_change;
      int n, k;
      bit ok;
      logic [15:0] e;
      btn1 = 8'h00; btn2 = 8'h00;
      // Late pull-down at bit-2 sample must be missed; early one at bit 5 seen.
      exp_q.push_back({8'h04, 8'h00});
      wait_pl(n, k, ok);
      repeat (22) @(negedge clk);
      ovr1_val = 1'b0; ovr1_en = 1'b1;
      repeat (2) @(negedge clk);
      ovr1_en = 1'b0;
      repeat (20) @(negedge clk);
      ovr1_val = 1'b0; ovr1_en = 1'b1;
      repeat (4) @(negedge clk);
      ovr1_en = 1'b0;
      wait_dv(k, ok);
      n_tests++;
      if (!ok || exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL late_sample: data_valid seen=%0b queue=%0d", ok, exp_q.size());
      end else begin
         e = exp_q.pop_front();
         if ({data1, data2} !== e) begin
            n_fail++;
            $display("FAIL late_sample: got %h want %h", {data1, data2}, e);
         end
      end
   endtask

   task automatic test_reset_mid;
      int n, k, viol;
      bit ok;
      logic [15:0] e;
      btn1 = 8'hA5; btn2 = 8'h3C;
      wait_pl(n, k, ok);
      repeat (29) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({pl1, pl2, sclk1, sclk2, dv} !== 5'b0 || {data1, data2} !== 16'h0000) begin
         n_fail++;
         $display("FAIL midreset_clear: lines %b words %h want 00000 0000",
                  {pl1, pl2, sclk1, sclk2, dv}, {data1, data2});
      end
      viol = 0;
      repeat (3) begin
         @(negedge clk);
         if (dv !== 1'b0) viol++;
      end
      n_tests++;
      if (viol != 0) begin
         n_fail++;
         $display("FAIL midreset_no_dv: %0d strobes want 0", viol);
      end
      exp_q.push_back({8'hA5, 8'h3C});
      rst = 1'b1;
      wait_pl(n, k, ok);
      n_tests++;
      if (!ok || n != PollCyc) begin
         n_fail++;
         $display("FAIL midreset_tick: pl after %0d cycles (seen=%0b) want %0d", n, ok, PollCyc);
      end
      wait_dv(k, ok);
      n_tests++;
      if (!ok || exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL midreset_frame: data_valid seen=%0b queue=%0d", ok, exp_q.size());
      end else begin
         e = exp_q.pop_front();
         if ({data1, data2} !== e) begin
            n_fail++;
            $display("FAIL midreset_frame: got %h want %h", {data1, data2}, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_pattern();
      test_waveform();
      test_extremes();
      test_hold();
      test_late_change();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
